// File: rtl/rca_seq_adder.sv
// Multi-cycle ripple-carry adder: adds CHUNK bits per clock through a short
// ripple chain and a registered carry, with a start/busy/done handshake.
// Final flags (carry-out, signed overflow, zero) are registered with the sum.
module rca_seq_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c0,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c,
    output logic             ovf,
    output logic             zero
);

    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);
    localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_q, b_q;
    logic             carry_q;
    logic [KW-1:0]    k;

    logic             accept;
    logic             last;
    int               shamt;
    logic [WIDTH-1:0] a_shift, b_shift;
    logic [CHUNK-1:0] a_chunk, b_chunk, sum_chunk;
    logic [CHUNK:0]   cy;
    logic [WIDTH-1:0] s_next;

    // New work is only taken when no addition is in flight.
    assign accept = start && ((state == IDLE) || (state == DONE));
    assign last   = (state == RUN) && (k == K_LAST);

    // Ripple chain over the current chunk; also builds the merged sum.
    always_comb begin
        shamt     = int'(k) * CHUNK;
        a_shift   = a_q >> shamt;
        b_shift   = b_q >> shamt;
        a_chunk   = a_shift[CHUNK-1:0];
        b_chunk   = b_shift[CHUNK-1:0];
        cy        = '0;
        sum_chunk = '0;
        cy[0]     = carry_q;
        for (int i = 0; i < CHUNK; i++) begin
            sum_chunk[i] = a_chunk[i] ^ b_chunk[i] ^ cy[i];
            cy[i+1]      = (a_chunk[i] & b_chunk[i]) | (cy[i] & (a_chunk[i] ^ b_chunk[i]));
        end
        s_next = (s & ~(CHUNK_MASK << shamt)) | (WIDTH'(sum_chunk) << shamt);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: if (start) state_next = RUN;
            RUN: begin
                busy = 1'b1;
                if (last) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = start ? RUN : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand latch, chunk stepping and result/flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            k       <= '0;
            s       <= '0;
            c       <= 1'b0;
            ovf     <= 1'b0;
            zero    <= 1'b0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= c0;
            k       <= '0;
            s       <= '0;
            c       <= 1'b0;
            ovf     <= 1'b0;
            zero    <= 1'b0;
        end else if (state == RUN) begin
            s       <= s_next;
            carry_q <= cy[CHUNK];
            k       <= k + KW'(1);
            if (last) begin
                // The top chunk holds the MSB, so cy[CHUNK-1] is the carry into it.
                c    <= cy[CHUNK];
                ovf  <= cy[CHUNK-1] ^ cy[CHUNK];
                zero <= (s_next == '0);
            end
        end
    end

endmodule

// File: tb/tb_rca_seq_adder.sv
// Directed bench for rca_seq_adder: an 8/2 instance for handshake and
// arithmetic corners, plus three 16-bit instances (CHUNK 1, 4, 16) for the
// latency/result sweep against a behavioural a+b+c0 model.
module tb_rca_seq_adder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // 8-bit, CHUNK=2 instance
    logic       start8, c08, busy8, done8, c8, ovf8, zero8;
    logic [7:0] a8, b8, s8;

    rca_seq_adder #(.WIDTH(8), .CHUNK(2)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .c0(c08),
        .busy(busy8), .done(done8), .s(s8), .c(c8), .ovf(ovf8), .zero(zero8)
    );

    // 16-bit instances sharing one stimulus
    logic             start16, c016;
    logic [15:0]      a16, b16;
    logic [2:0]       busyw, donew, cw, ovfw, zerow;
    logic [2:0][15:0] sw;

    rca_seq_adder #(.WIDTH(16), .CHUNK(1)) dut16_1 (
        .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .c0(c016),
        .busy(busyw[0]), .done(donew[0]), .s(sw[0]), .c(cw[0]), .ovf(ovfw[0]), .zero(zerow[0])
    );
    rca_seq_adder #(.WIDTH(16), .CHUNK(4)) dut16_4 (
        .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .c0(c016),
        .busy(busyw[1]), .done(donew[1]), .s(sw[1]), .c(cw[1]), .ovf(ovfw[1]), .zero(zerow[1])
    );
    rca_seq_adder #(.WIDTH(16), .CHUNK(16)) dut16_16 (
        .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .c0(c016),
        .busy(busyw[2]), .done(donew[2]), .s(sw[2]), .c(cw[2]), .ovf(ovfw[2]), .zero(zerow[2])
    );

    // Stimulus only: pulse start on the 8-bit DUT and wait (bounded) for done.
    // lat counts edges from the start-sampling edge (inclusive); -1 on timeout.
    task automatic run8(input logic [7:0] ai, input logic [7:0] bi, input logic ci,
                        output int lat, output int busy_cnt);
        @(negedge clk);
        a8 = ai; b8 = bi; c08 = ci; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        lat = 1; busy_cnt = 0;
        while (!done8 && lat < 20) begin
            if (busy8) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        if (!done8) lat = -1;
    endtask

    task automatic test_reset;
        rst = 1'b1; start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; c08 = 1'b1;
        start16 = 1'b1; a16 = 16'h1234; b16 = 16'h1111; c016 = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy8); end
        checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done8); end
        checks++; if (s8 !== 8'h00) begin errors++; $display("FAIL reset_s: got %h want 00", s8); end
        checks++; if ({c8, ovf8, zero8} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {c8, ovf8, zero8}); end
        checks++; if ({busyw, donew} !== 6'b0) begin errors++; $display("FAIL reset_16: got %b want 000000", {busyw, donew}); end
        start8 = 1'b0; start16 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b want 0", busy8); end
    endtask

    task automatic test_basic;
        int lat, bc;
        run8(8'h01, 8'h01, 1'b0, lat, bc);
        checks++; if (lat != 5) begin errors++; $display("FAIL basic_latency: got %0d want 5", lat); end
        checks++; if (bc != 4) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 4", bc); end
        checks++; if (s8 !== 8'h02) begin errors++; $display("FAIL basic_s: got %h want 02", s8); end
        checks++; if ({c8, ovf8, zero8} !== 3'b000) begin errors++; $display("FAIL basic_flags: got %b want 000", {c8, ovf8, zero8}); end
        @(negedge clk);
        checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b want 0", done8); end
        checks++; if (s8 !== 8'h02) begin errors++; $display("FAIL basic_hold_s: got %h want 02", s8); end
    endtask

    task automatic test_wrap;
        logic [7:0] va [2] = '{8'hFF, 8'hFF};
        logic [7:0] vb [2] = '{8'h01, 8'h00};
        logic       vc [2] = '{1'b0, 1'b1};
        int lat, bc;
        for (int i = 0; i < 2; i++) begin
            run8(va[i], vb[i], vc[i], lat, bc);
            checks++; if (lat != 5) begin errors++; $display("FAIL wrap%0d_latency: got %0d want 5", i, lat); end
            checks++; if (s8 !== 8'h00) begin errors++; $display("FAIL wrap%0d_s: got %h want 00", i, s8); end
            checks++; if ({c8, ovf8, zero8} !== 3'b101) begin errors++; $display("FAIL wrap%0d_flags(c,ovf,zero): got %b want 101", i, {c8, ovf8, zero8}); end
        end
    endtask

    task automatic test_overflow;
        logic [7:0] va [3] = '{8'hFF, 8'h7F, 8'h81};
        logic [7:0] vb [3] = '{8'hFF, 8'h01, 8'h81};
        logic [7:0] es [3] = '{8'hFE, 8'h80, 8'h02};
        logic [2:0] ef [3] = '{3'b100, 3'b010, 3'b110};
        int lat, bc;
        for (int i = 0; i < 3; i++) begin
            run8(va[i], vb[i], 1'b0, lat, bc);
            checks++; if (s8 !== es[i]) begin errors++; $display("FAIL ovf%0d_s: got %h want %h", i, s8, es[i]); end
            checks++; if ({c8, ovf8, zero8} !== ef[i]) begin errors++; $display("FAIL ovf%0d_flags(c,ovf,zero): got %b want %b", i, {c8, ovf8, zero8}, ef[i]); end
        end
    endtask

    task automatic test_back_to_back;
        int lat, bc;
        run8(8'h10, 8'h05, 1'b0, lat, bc);
        checks++; if (s8 !== 8'h15) begin errors++; $display("FAIL b2b_first_s: got %h want 15", s8); end
        // still in the done cycle: request the next operation
        a8 = 8'h19; b8 = 8'h31; c08 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; a8 = 8'hEE; b8 = 8'hEE; c08 = 1'b1;
        checks++; if ({busy8, done8} !== 2'b10) begin errors++; $display("FAIL b2b_no_gap(busy,done): got %b want 10", {busy8, done8}); end
        lat = 1;
        while (!done8 && lat < 20) begin @(negedge clk); lat++; end
        checks++; if (lat != 5) begin errors++; $display("FAIL b2b_latency: got %0d want 5", lat); end
        checks++; if (s8 !== 8'h4A) begin errors++; $display("FAIL b2b_s: got %h want 4a", s8); end
        checks++; if ({c8, ovf8, zero8} !== 3'b000) begin errors++; $display("FAIL b2b_flags: got %b want 000", {c8, ovf8, zero8}); end
    endtask

    task automatic test_ignore_start;
        int lat;
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h20; c08 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; lat = 1;
        @(negedge clk);
        lat++;
        a8 = 8'h55; b8 = 8'h55; c08 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        lat++;
        start8 = 1'b0;
        while (!done8 && lat < 20) begin @(negedge clk); lat++; end
        checks++; if (lat != 5) begin errors++; $display("FAIL ignore_latency: got %0d want 5", lat); end
        checks++; if (s8 !== 8'h30) begin errors++; $display("FAIL ignore_s: got %h want 30", s8); end
        checks++; if (c8 !== 1'b0) begin errors++; $display("FAIL ignore_c: got %b want 0", c8); end
    endtask

    task automatic test_reset_midop;
        int lat, bc;
        int seen_done;
        @(negedge clk);
        a8 = 8'h03; b8 = 8'h03; c08 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if ({busy8, done8} !== 2'b00) begin errors++; $display("FAIL midrst_busy_done: got %b want 00", {busy8, done8}); end
        checks++; if ({s8, c8, ovf8, zero8} !== 11'h0) begin errors++; $display("FAIL midrst_results: got s=%h c=%b want s=00 c=0", s8, c8); end
        seen_done = 0;
        repeat (10) begin
            @(negedge clk);
            if (done8) seen_done++;
        end
        checks++; if (seen_done != 0) begin errors++; $display("FAIL midrst_no_done: got %0d done cycles want 0", seen_done); end
        run8(8'h03, 8'h03, 1'b1, lat, bc);
        checks++; if (lat != 5) begin errors++; $display("FAIL midrst_restart_latency: got %0d want 5", lat); end
        checks++; if (s8 !== 8'h07) begin errors++; $display("FAIL midrst_restart_s: got %h want 07", s8); end
    endtask

    task automatic test_sweep16;
        logic [15:0] va [8];
        logic [15:0] vb [8];
        logic        vc [8];
        int          lat_exp [3] = '{17, 5, 2};
        int          lat [3];
        logic [15:0] gs [3];
        logic        gc [3], go [3], gz [3];
        logic [15:0] es;
        logic        ec, eo, ez;
        int          cnt;
        va[0] = 16'hFFFF; vb[0] = 16'h0001; vc[0] = 1'b0;
        va[1] = 16'h7FFF; vb[1] = 16'h0001; vc[1] = 1'b0;
        va[2] = 16'h8000; vb[2] = 16'h8000; vc[2] = 1'b0;
        va[3] = 16'h1234; vb[3] = 16'h4321; vc[3] = 1'b1;
        for (int i = 4; i < 8; i++) begin
            va[i] = 16'($urandom); vb[i] = 16'($urandom); vc[i] = 1'($urandom);
        end
        for (int i = 0; i < 8; i++) begin
            {ec, es} = 17'(va[i]) + 17'(vb[i]) + 17'(vc[i]);
            eo = (va[i][15] == vb[i][15]) && (es[15] != va[i][15]);
            ez = (es == 16'h0);
            @(negedge clk);
            a16 = va[i]; b16 = vb[i]; c016 = vc[i]; start16 = 1'b1;
            @(negedge clk);
            start16 = 1'b0; a16 = ~va[i]; b16 = 16'h0; c016 = 1'b0;
            cnt = 1;
            for (int j = 0; j < 3; j++) lat[j] = -1;
            while (cnt < 40 && (lat[0] < 0 || lat[1] < 0 || lat[2] < 0)) begin
                for (int j = 0; j < 3; j++)
                    if (lat[j] < 0 && donew[j]) begin
                        lat[j] = cnt; gs[j] = sw[j]; gc[j] = cw[j]; go[j] = ovfw[j]; gz[j] = zerow[j];
                    end
                if (lat[0] < 0 || lat[1] < 0 || lat[2] < 0) begin
                    @(negedge clk);
                    cnt++;
                end
            end
            for (int j = 0; j < 3; j++) begin
                checks++; if (lat[j] != lat_exp[j]) begin errors++; $display("FAIL sweep%0d_dut%0d_latency: got %0d want %0d", i, j, lat[j], lat_exp[j]); end
                checks++; if (gs[j] !== es) begin errors++; $display("FAIL sweep%0d_dut%0d_s: got %h want %h", i, j, gs[j], es); end
                checks++; if ({gc[j], go[j], gz[j]} !== {ec, eo, ez}) begin errors++; $display("FAIL sweep%0d_dut%0d_flags(c,ovf,zero): got %b want %b", i, j, {gc[j], go[j], gz[j]}, {ec, eo, ez}); end
            end
        end
    endtask

    initial begin
        rst = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0; c08 = 1'b0;
        start16 = 1'b0; a16 = '0; b16 = '0; c016 = 1'b0;
        test_reset;
        test_basic;
        test_wrap;
        test_overflow;
        test_back_to_back;
        test_ignore_start;
        test_reset_midop;
        test_sweep16;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
